// File: rtl/rx_pkt_err_filter_if.sv
// AXI4-Stream style bundle used on both sides of the RX packet error filter.
// The err field carries per-segment LBUS error flags on the input side. The
// filter's output side drives it to zero.
interface rx_pkt_err_filter_if #(
  parameter int DW = 512
) ();
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;
  logic [3:0]      err;

  modport master (output tdata, tkeep, tlast, tvalid, err, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, err, output tready);
endinterface

// File: rtl/rx_pkt_err_filter.sv
// Store-and-forward RX packet filter. Each packet from the converter is
// buffered in full. The packet is dropped, by rewinding the write pointer, if
// any beat carried an error or if the packet did not fit. Only committed
// packets are replayed on a back-pressurable stream through a
// first-word-fall-through output register.
module rx_pkt_err_filter #(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  rx_pkt_err_filter_if.slave         s_axis,
  rx_pkt_err_filter_if.master        m_axis,
  output logic [31:0]                pkt_ok_cnt,
  output logic [31:0]                pkt_err_cnt,
  output logic [31:0]                pkt_ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = 512 + 64 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic {IDLE, IN_PKT} wr_state_e;

  logic [BW-1:0] r_ram [DEPTH];

  wr_state_e     r_state, w_state_nxt;
  logic [PW-1:0] r_wr_ptr, r_start_ptr, r_commit_ptr, r_rd_ptr;
  logic          r_err_acc, r_ovf;
  logic [31:0]   r_ok_cnt, r_err_cnt, r_ovf_cnt;

  logic          r_out_valid;
  logic [511:0]  r_out_data;
  logic [63:0]   r_out_keep;
  logic          r_out_last;

  logic          w_full, w_ovf, w_err, w_write;
  logic [PW-1:0] w_pkt_start;
  logic          w_pop, w_load;
  logic [PW-1:0] w_rd_next;
  logic [BW-1:0] w_rd_word;

  // The input has no back-pressure, so it is always ready. The output side
  // never reports segment errors.
  assign s_axis.tready = 1'b1;
  assign m_axis.err    = 4'b0000;

  // rd_ptr still owns the slot that sits in the output register, so that slot
  // stays reserved until its handshake. This value is taken before the edge.
  assign w_full      = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
  assign w_pkt_start = (r_state == IDLE) ? r_wr_ptr : r_start_ptr;
  assign w_ovf       = r_ovf | w_full;
  assign w_err       = r_err_acc | (|s_axis.err);
  assign w_write     = s_axis.tvalid & ~w_full & ~r_ovf;

  // Packet-position state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next packet position: any tlast beat ends the packet.
  always_comb begin
    // NOTE: the default assignment comes first so that every path assigns the
    // signal and no latch is inferred.
    w_state_nxt = r_state;
    if (s_axis.tvalid) w_state_nxt = s_axis.tlast ? IDLE : IN_PKT;
  end

  // Beat storage: data, keep and last packed into one word.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset. The pointers decide which entries are live,
    // and a reset-free array can map onto block RAM.
    if (w_write) r_ram[r_wr_ptr[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
  end

  // Write pointers, drop flags, and per-packet verdict on the tlast beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_start_ptr  <= '0;
      r_commit_ptr <= '0;
      r_err_acc    <= 1'b0;
      r_ovf        <= 1'b0;
      r_ok_cnt     <= '0;
      r_err_cnt    <= '0;
      r_ovf_cnt    <= '0;
    end else if (s_axis.tvalid) begin
      if (r_state == IDLE) r_start_ptr <= r_wr_ptr;
      if (s_axis.tlast) begin
        r_err_acc <= 1'b0;
        r_ovf     <= 1'b0;
        if (w_ovf) begin
          r_wr_ptr  <= w_pkt_start;
          r_ovf_cnt <= r_ovf_cnt + 32'd1;
        end else if (w_err) begin
          r_wr_ptr  <= w_pkt_start;
          r_err_cnt <= r_err_cnt + 32'd1;
        end else begin
          r_wr_ptr     <= r_wr_ptr + ONE_P;
          r_commit_ptr <= r_wr_ptr + ONE_P;
          r_ok_cnt     <= r_ok_cnt + 32'd1;
        end
      end else begin
        r_err_acc <= w_err;
        r_ovf     <= w_ovf;
        if (w_write) r_wr_ptr <= r_wr_ptr + ONE_P;
      end
    end
  end

  // Read side: refill the output register whenever it is empty or being
  // consumed, but only from committed beats.
  assign w_pop     = r_out_valid & m_axis.tready;
  assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_load    = (w_rd_next != r_commit_ptr) & (~r_out_valid | w_pop);
  assign w_rd_word = r_ram[w_rd_next[AW-1:0]];

  // Output register and read pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (w_load) begin
        r_out_valid                          <= 1'b1;
        {r_out_data, r_out_keep, r_out_last} <= w_rd_word;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = r_out_valid;
  assign m_axis.tdata  = r_out_data;
  assign m_axis.tkeep  = r_out_keep;
  assign m_axis.tlast  = r_out_last;

  assign pkt_ok_cnt  = r_ok_cnt;
  assign pkt_err_cnt = r_err_cnt;
  assign pkt_ovf_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_rx_pkt_err_filter.sv
// Testbench for rx_pkt_err_filter. One instance uses DEPTH=256 for the
// directed, random and reset tests. A second instance uses DEPTH=4 for the
// overflow tests. Expected beats are queued when they are driven and are
// compared as each output handshake occurs.
module tb_rx_pkt_err_filter;

  typedef logic [576:0] beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rx_pkt_err_filter_if sif ();
  rx_pkt_err_filter_if mif ();
  rx_pkt_err_filter_if sif4 ();
  rx_pkt_err_filter_if mif4 ();

  logic [31:0] ok, err, ovf, ok4, err4, ovf4;

  rx_pkt_err_filter #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(sif), .m_axis(mif),
    .pkt_ok_cnt(ok), .pkt_err_cnt(err), .pkt_ovf_cnt(ovf)
  );

  rx_pkt_err_filter #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .s_axis(sif4), .m_axis(mif4),
    .pkt_ok_cnt(ok4), .pkt_err_cnt(err4), .pkt_ovf_cnt(ovf4)
  );

  beat_t exp_q[$];
  beat_t exp4_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    rnd_en   = 1'b0;

  task automatic check(input string tag, input beat_t obs, input beat_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock; inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) mif.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_idle();
    sif.tvalid  = 1'b0;
    sif4.tvalid = 1'b0;
  endtask

  task automatic drive(input bit d4, input beat_t b, input logic [3:0] e);
    if (d4) begin
      sif4.tvalid = 1'b1;
      {sif4.tdata, sif4.tkeep, sif4.tlast} = b;
      sif4.err = e;
    end else begin
      sif.tvalid = 1'b1;
      {sif.tdata, sif.tkeep, sif.tlast} = b;
      sif.err = e;
    end
    tick();
  endtask

  // Drive one packet back-to-back. Push it to the scoreboard if it should
  // pass the filter.
  task automatic send_pkt(input bit d4, input int len, input int err_idx,
                          input logic [3:0] err_val, input logic [63:0] last_keep,
                          input bit push);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b[576:65] = rnd512();
      b[64:1]   = (i == len - 1) ? last_keep : 64'hFFFF_FFFF_FFFF_FFFF;
      b[0]      = (i == len - 1);
      if (push) begin
        if (d4) exp4_q.push_back(b);
        else    exp_q.push_back(b);
      end
      drive(d4, b, (i == err_idx) ? err_val : 4'b0000);
    end
  endtask

  task automatic wait_drain(input bit d4, input string tag);
    int n = 0;
    while ((d4 ? exp4_q.size() : exp_q.size()) != 0 && n < 5000) begin
      tick();
      n++;
    end
    check(tag, beat_t'(d4 ? exp4_q.size() : exp_q.size()), beat_t'(0));
  endtask

  // Output monitors: compare each handshake with the scoreboard and check
  // that a stalled beat is held.
  bit    stall, stall4;
  beat_t stall_beat, stall_beat4;

  always @(negedge clk) begin
    beat_t obs;
    obs = {mif.tdata, mif.tkeep, mif.tlast};
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("m_hold_valid", beat_t'(mif.tvalid), beat_t'(1));
        check("m_hold_data", obs, stall_beat);
      end
      if (mif.tvalid && mif.tready) begin
        if (exp_q.size() == 0) check("m_unexpected_beat", obs, beat_t'('x));
        else                   check("m_beat", obs, exp_q.pop_front());
      end
      stall      = mif.tvalid && !mif.tready;
      stall_beat = obs;
    end
  end

  always @(negedge clk) begin
    beat_t obs;
    obs = {mif4.tdata, mif4.tkeep, mif4.tlast};
    if (!rst_n) begin
      stall4 = 1'b0;
    end else begin
      if (stall4) begin
        check("m4_hold_valid", beat_t'(mif4.tvalid), beat_t'(1));
        check("m4_hold_data", obs, stall_beat4);
      end
      if (mif4.tvalid && mif4.tready) begin
        if (exp4_q.size() == 0) check("m4_unexpected_beat", obs, beat_t'('x));
        else                    check("m4_beat", obs, exp4_q.pop_front());
      end
      stall4      = mif4.tvalid && !mif4.tready;
      stall_beat4 = obs;
    end
  end

  initial begin
    int n_ok, n_err, w;
    logic [31:0] ok0, err0, ovf0;

    // Reset.
    rst_n = 1'b0;
    sif.tvalid = 1'b0; sif.tdata = '0; sif.tkeep = '0; sif.tlast = 1'b0; sif.err = '0;
    sif4.tvalid = 1'b0; sif4.tdata = '0; sif4.tkeep = '0; sif4.tlast = 1'b0; sif4.err = '0;
    mif.tready = 1'b1;
    mif4.tready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_tvalid", beat_t'(mif.tvalid), beat_t'(0));
    check("rst_tdata", {mif.tdata, mif.tkeep, mif.tlast}, beat_t'(0));
    check("rst_ok", beat_t'(ok), beat_t'(0));
    check("rst_err", beat_t'(err), beat_t'(0));
    check("rst_ovf", beat_t'(ovf), beat_t'(0));
    check("rst4_tvalid", beat_t'(mif4.tvalid), beat_t'(0));

    // Single 3-beat clean packet; first beat shows 2 cycles after the tlast beat.
    send_pkt(0, 3, -1, 4'b0000, 64'hFFFF_0000_0000_0000, 1);
    set_idle();
    check("lat_t1_tvalid", beat_t'(mif.tvalid), beat_t'(0));
    tick();
    check("lat_t2_tvalid", beat_t'(mif.tvalid), beat_t'(1));
    check("lat_t2_beat", {mif.tdata, mif.tkeep, mif.tlast}, exp_q[0]);
    wait_drain(0, "t1_drain");
    check("t1_ok", beat_t'(ok), beat_t'(1));

    // Errored 2-beat packet followed directly by a clean 1-beat packet.
    send_pkt(0, 2, 0, 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    send_pkt(0, 1, -1, 4'b0000, 64'hF000_0000_0000_0000, 1);
    set_idle();
    wait_drain(0, "t2_drain");
    check("t2_err", beat_t'(err), beat_t'(1));
    check("t2_ok", beat_t'(ok), beat_t'(2));

    // DEPTH=4 with tready low: 3-beat packet fits, next 3-beat packet overflows.
    mif4.tready = 1'b0;
    send_pkt(1, 3, -1, 4'b0000, 64'hFFFF_FFFF_0000_0000, 1);
    send_pkt(1, 3, -1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    set_idle();
    tick();
    check("t3_ovf", beat_t'(ovf4), beat_t'(1));
    check("t3_ok", beat_t'(ok4), beat_t'(1));
    check("t3_stall_valid", beat_t'(mif4.tvalid), beat_t'(1));
    check("t3_stall_beat", {mif4.tdata, mif4.tkeep, mif4.tlast}, exp4_q[0]);
    mif4.tready = 1'b1;
    wait_drain(1, "t3_drain");
    repeat (3) tick();
    check("t3_no_extra", beat_t'(mif4.tvalid), beat_t'(0));

    // Overflow plus error: overflow wins. Then an exact DEPTH-beat packet fits.
    mif4.tready = 1'b0;
    send_pkt(1, 5, 1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    set_idle();
    tick();
    check("t4_ovf", beat_t'(ovf4), beat_t'(2));
    check("t4_err", beat_t'(err4), beat_t'(0));
    check("t4_nothing_out", beat_t'(mif4.tvalid), beat_t'(0));
    send_pkt(1, 4, -1, 4'b0000, 64'h8000_0000_0000_0000, 1);
    set_idle();
    tick();
    check("t4_full_fit_ok", beat_t'(ok4), beat_t'(2));
    check("t4_full_fit_ovf", beat_t'(ovf4), beat_t'(2));
    mif4.tready = 1'b1;
    wait_drain(1, "t4_drain");

    // Random traffic: 1000 packets of 1-20 beats, about 10% errored, with
    // random tready. A packet is only started when it is sure to fit.
    ok0 = ok; err0 = err; ovf0 = ovf;
    n_ok = 0; n_err = 0;
    rnd_en = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len, eidx;
      bit bad;
      len  = int'($urandom_range(1, 20));
      bad  = ($urandom_range(0, 9) == 0);
      eidx = bad ? int'($urandom_range(0, len - 1)) : -1;
      w = 0;
      while (exp_q.size() + len > 256 && w < 5000) begin
        set_idle();
        tick();
        w++;
      end
      if (w >= 5000) check("rnd_space_timeout", beat_t'(exp_q.size()), beat_t'(256 - len));
      send_pkt(0, len, eidx, 4'($urandom_range(1, 15)),
               {1'b1, 63'($urandom) << 31 | 63'($urandom)}, !bad);
      if (bad) n_err++;
      else     n_ok++;
    end
    set_idle();
    rnd_en = 1'b0;
    mif.tready = 1'b1;
    wait_drain(0, "rnd_drain");
    check("rnd_ok", beat_t'(ok - ok0), beat_t'(n_ok));
    check("rnd_err", beat_t'(err - err0), beat_t'(n_err));
    check("rnd_ovf", beat_t'(ovf - ovf0), beat_t'(0));
    check("rnd_total", beat_t'((ok - ok0) + (err - err0) + (ovf - ovf0)), beat_t'(1000));

    // Reset during readout and mid-packet.
    send_pkt(0, 6, -1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    for (int i = 0; i < 3; i++) drive(0, {rnd512(), 64'hFFFF_FFFF_FFFF_FFFF, 1'b0}, 4'b0000);
    rst_n = 1'b0;
    set_idle();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    check("rst2_tvalid", beat_t'(mif.tvalid), beat_t'(0));
    check("rst2_ok", beat_t'(ok), beat_t'(0));
    check("rst2_err", beat_t'(err), beat_t'(0));
    check("rst2_ovf", beat_t'(ovf), beat_t'(0));
    check("rst2_ovf4", beat_t'(ovf4), beat_t'(0));
    send_pkt(0, 2, -1, 4'b0000, 64'hFF00_0000_0000_0000, 1);
    set_idle();
    wait_drain(0, "rst2_drain");
    check("rst2_post_ok", beat_t'(ok), beat_t'(1));
    check("rst2_post_err", beat_t'(err), beat_t'(0));
    repeat (2) tick();
    check("rst2_idle", beat_t'(mif.tvalid), beat_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
